// File: rtl/control_packet_1_to_n_router_pkg.sv
// rtl/control_packet_1_to_n_router_pkg.sv - ControlPacket types, FIFO state signals and route-id decode.
package control_packet_1_to_n_router_pkg;

  localparam int NUM_CONTROL_RECEIVER_DEFAULT = 4;
  localparam int ROUTE_ID_WIDTH = $clog2(NUM_CONTROL_RECEIVER_DEFAULT) + 1;
  localparam logic [ROUTE_ID_WIDTH-1:0] ROUTE_ID_BROADCAST = '1;

  typedef struct packed {
    logic [7:0]  route;
    logic [23:0] data;
  } ControlPacketPayload;

  typedef struct packed {
    logic                valid;
    ControlPacketPayload payload;
  } ControlPacket;

  typedef struct packed {
    logic rd_en;
  } FIFOStateSignalsInput;

  typedef struct packed {
    logic empty;
    logic prog_full;
  } FIFOStateSignalsOutput;

  // Only the low ROUTE_ID_WIDTH bits of the route byte select a destination.
  function automatic logic [ROUTE_ID_WIDTH-1:0] control_route_id(input ControlPacketPayload p);
    return p.route[ROUTE_ID_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/control_packet_fifo_sync.sv
// rtl/control_packet_fifo_sync.sv - Synchronous FIFO with registered empty/full/prog_full flags.
module control_packet_fifo_sync #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int PROG_THRESH = 3
) (
  input  logic                  ap_clk,
  input  logic                  areset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  prog_full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic [AW:0]           count_nxt;
  logic                  do_wr;
  logic                  do_rd;

  // A pop frees a slot on the same edge, so a push into a full FIFO is taken when it coincides with a pop.
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_wr && !do_rd) begin
      count_nxt = count + (AW+1)'(1);
    end else if (do_rd && !do_wr) begin
      count_nxt = count - (AW+1)'(1);
    end
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      prog_full <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nxt;
      empty     <= (count_nxt == '0);
      full      <= (count_nxt == (AW+1)'(DEPTH));
      prog_full <= (count_nxt >= (AW+1)'(PROG_THRESH));
    end
  end

  always_ff @(posedge ap_clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/control_packet_1_to_n_router.sv
// rtl/control_packet_1_to_n_router.sv - Routes one ControlPacket stream to N destination FIFOs by route id.
// Optional broadcast on all-ones route id: CONTROL_ROUTER_BROADCAST_EN.
module control_packet_1_to_n_router
  import control_packet_1_to_n_router_pkg::*;
#(
  parameter int NUM_CONTROL_RECEIVER = NUM_CONTROL_RECEIVER_DEFAULT,
  parameter int IN_FIFO_DEPTH        = 8,
  parameter int IN_PROG_THRESH       = 4,
  parameter int OUT_FIFO_DEPTH       = 4,
  parameter int OUT_PROG_THRESH      = 3
) (
  input  logic                                             ap_clk,
  input  logic                                             areset,
  input  ControlPacket                                     request_in,
  output FIFOStateSignalsOutput                            fifo_request_signals_out,
  input  FIFOStateSignalsInput  [NUM_CONTROL_RECEIVER-1:0] fifo_response_signals_in,
  output FIFOStateSignalsOutput [NUM_CONTROL_RECEIVER-1:0] fifo_response_signals_out,
  output ControlPacket          [NUM_CONTROL_RECEIVER-1:0] request_out,
  output logic                                             fifo_setup_signal,
  output logic                                             overflow_error,
  output logic [15:0]                                      drop_count
);

  localparam int IDX_W = $clog2(NUM_CONTROL_RECEIVER);
  localparam int PW    = $bits(ControlPacketPayload);

  ControlPacket                                 in_reg;
  ControlPacketPayload                          in_head;
  logic                                         in_empty;
  logic                                         in_full;
  logic                                         in_prog_full;
  logic                                         in_pop;
  logic                                         drop;
  logic [1:0]                                   setup_sr;
  logic [ROUTE_ID_WIDTH-1:0]                    head_id;
  logic [IDX_W-1:0]                             head_idx;
  logic                                         is_bcast;
  logic [NUM_CONTROL_RECEIVER-1:0]              dest_push;
  logic [NUM_CONTROL_RECEIVER-1:0]              dest_pop;
  logic [NUM_CONTROL_RECEIVER-1:0]              dest_empty;
  logic [NUM_CONTROL_RECEIVER-1:0]              dest_full;
  logic [NUM_CONTROL_RECEIVER-1:0]              dest_prog_full;
  ControlPacketPayload [NUM_CONTROL_RECEIVER-1:0] dest_head;

  assign fifo_setup_signal               = ~setup_sr[1];
  assign fifo_request_signals_out.empty     = in_empty;
  assign fifo_request_signals_out.prog_full = in_prog_full;

  control_packet_fifo_sync #(
    .DATA_WIDTH (PW),
    .DEPTH      (IN_FIFO_DEPTH),
    .PROG_THRESH(IN_PROG_THRESH)
  ) u_in_fifo (
    .ap_clk   (ap_clk),
    .areset   (areset),
    .wr_en    (in_reg.valid),
    .wr_data  (in_reg.payload),
    .rd_en    (in_pop),
    .rd_data  (in_head),
    .empty    (in_empty),
    .full     (in_full),
    .prog_full(in_prog_full)
  );

  assign head_id  = control_route_id(in_head);
  assign head_idx = head_id[IDX_W-1:0];

`ifdef CONTROL_ROUTER_BROADCAST_EN
  assign is_bcast = (head_id == ROUTE_ID_BROADCAST);
`else
  assign is_bcast = 1'b0;
`endif

  // Head-of-line dispatch: a blocked head stalls everything behind it so order is preserved.
  always_comb begin
    in_pop    = 1'b0;
    dest_push = '0;
    drop      = 1'b0;
    if (!in_empty) begin
      if (is_bcast) begin
        if (~|dest_full) begin
          dest_push = '1;
          in_pop    = 1'b1;
        end
      end else if (head_id < ROUTE_ID_WIDTH'(NUM_CONTROL_RECEIVER)) begin
        if (!dest_full[head_idx]) begin
          dest_push[head_idx] = 1'b1;
          in_pop              = 1'b1;
        end
      end else begin
        in_pop = 1'b1;
        drop   = 1'b1;
      end
    end
  end

  always_comb begin
    dest_pop = '0;
    for (int i = 0; i < NUM_CONTROL_RECEIVER; i++) begin
      dest_pop[i] = fifo_response_signals_in[i].rd_en & ~dest_empty[i];
    end
  end

  for (genvar g = 0; g < NUM_CONTROL_RECEIVER; g++) begin : g_dest
    control_packet_fifo_sync #(
      .DATA_WIDTH (PW),
      .DEPTH      (OUT_FIFO_DEPTH),
      .PROG_THRESH(OUT_PROG_THRESH)
    ) u_dest_fifo (
      .ap_clk   (ap_clk),
      .areset   (areset),
      .wr_en    (dest_push[g]),
      .wr_data  (in_head),
      .rd_en    (dest_pop[g]),
      .rd_data  (dest_head[g]),
      .empty    (dest_empty[g]),
      .full     (dest_full[g]),
      .prog_full(dest_prog_full[g])
    );
    assign fifo_response_signals_out[g].empty     = dest_empty[g];
    assign fifo_response_signals_out[g].prog_full = dest_prog_full[g];
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      setup_sr       <= 2'b00;
      in_reg         <= '0;
      overflow_error <= 1'b0;
      drop_count     <= 16'd0;
      request_out    <= '0;
    end else begin
      setup_sr       <= {setup_sr[0], 1'b1};
      in_reg.valid   <= request_in.valid & ~fifo_setup_signal;
      in_reg.payload <= request_in.payload;
      if (in_reg.valid && in_full && !in_pop) overflow_error <= 1'b1;
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      for (int i = 0; i < NUM_CONTROL_RECEIVER; i++) begin
        request_out[i].valid   <= dest_pop[i];
        request_out[i].payload <= dest_head[i];
      end
    end
  end

endmodule

// File: tb/tb_control_packet_1_to_n_router.sv
// tb/tb_control_packet_1_to_n_router.sv - Randomized bench for control_packet_1_to_n_router against a queue model.
module tb_control_packet_1_to_n_router;
  import control_packet_1_to_n_router_pkg::*;

  localparam int N        = 4;
  localparam int IN_DEPTH = 8;
  localparam int OUT_DEPTH = 4;
`ifdef CONTROL_ROUTER_BROADCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic                            ap_clk;
  logic                            areset;
  ControlPacket                    request_in;
  FIFOStateSignalsOutput           fifo_request_signals_out;
  FIFOStateSignalsInput  [N-1:0]   fifo_response_signals_in;
  FIFOStateSignalsOutput [N-1:0]   fifo_response_signals_out;
  ControlPacket          [N-1:0]   request_out;
  logic                            fifo_setup_signal;
  logic                            overflow_error;
  logic [15:0]                     drop_count;

  control_packet_1_to_n_router dut (
    .ap_clk                   (ap_clk),
    .areset                   (areset),
    .request_in               (request_in),
    .fifo_request_signals_out (fifo_request_signals_out),
    .fifo_response_signals_in (fifo_response_signals_in),
    .fifo_response_signals_out(fifo_response_signals_out),
    .request_out              (request_out),
    .fifo_setup_signal        (fifo_setup_signal),
    .overflow_error           (overflow_error),
    .drop_count               (drop_count)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_vectors;
  int n_miscompares;

  // Reference model: plain queues following the routing rules edge by edge.
  ControlPacketPayload in_q[$];
  ControlPacketPayload dq[N][$];
  bit                  m_stage_v;
  ControlPacketPayload m_stage;
  int                  m_setup_cnt;
  bit                  m_ovf;
  int                  m_drop;
  bit                  m_out_v[N];
  ControlPacketPayload m_out_d[N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    in_q.delete();
    for (int i = 0; i < N; i++) begin
      dq[i].delete();
      m_out_v[i] = 1'b0;
    end
    m_stage_v   = 1'b0;
    m_setup_cnt = 0;
    m_ovf       = 1'b0;
    m_drop      = 0;
  endtask

  task automatic model_step();
    bit full_pre[N];
    bit any_full;
    int id;
    any_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      full_pre[i] = (dq[i].size() == OUT_DEPTH);
      any_full    = any_full | full_pre[i];
    end
    for (int i = 0; i < N; i++) begin
      m_out_v[i] = fifo_response_signals_in[i].rd_en && (dq[i].size() > 0);
      if (m_out_v[i]) m_out_d[i] = dq[i].pop_front();
    end
    if (in_q.size() > 0) begin
      id = int'(in_q[0].route) % (1 << ROUTE_ID_WIDTH);
      if (BCAST && id == (1 << ROUTE_ID_WIDTH) - 1) begin
        if (!any_full) begin
          for (int i = 0; i < N; i++) dq[i].push_back(in_q[0]);
          void'(in_q.pop_front());
        end
      end else if (id < N) begin
        if (!full_pre[id]) dq[id].push_back(in_q.pop_front());
      end else begin
        void'(in_q.pop_front());
        if (m_drop < 65535) m_drop++;
      end
    end
    if (m_stage_v) begin
      if (in_q.size() < IN_DEPTH) in_q.push_back(m_stage);
      else m_ovf = 1'b1;
    end
    m_stage_v = request_in.valid && (m_setup_cnt >= 2);
    m_stage   = request_in.payload;
    if (m_setup_cnt < 2) m_setup_cnt++;
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      check($sformatf("out%0d_valid", i), 64'(request_out[i].valid), 64'(m_out_v[i]));
      if (m_out_v[i]) check($sformatf("out%0d_payload", i), 64'(request_out[i].payload), 64'(m_out_d[i]));
      check($sformatf("dest%0d_empty", i), 64'(fifo_response_signals_out[i].empty), 64'(dq[i].size() == 0));
      check($sformatf("dest%0d_prog_full", i), 64'(fifo_response_signals_out[i].prog_full), 64'(dq[i].size() >= 3));
    end
    check("in_empty", 64'(fifo_request_signals_out.empty), 64'(in_q.size() == 0));
    check("in_prog_full", 64'(fifo_request_signals_out.prog_full), 64'(in_q.size() >= 4));
    check("setup", 64'(fifo_setup_signal), 64'(m_setup_cnt < 2));
    check("overflow_error", 64'(overflow_error), 64'(m_ovf));
    check("drop_count", 64'(drop_count), 64'(m_drop));
  endtask

  task automatic cycle();
    @(posedge ap_clk);
    if (areset) model_reset();
    else model_step();
    @(negedge ap_clk);
    compare_all();
  endtask

  task automatic drive(input bit v, input logic [7:0] route, input logic [3:0] rd);
    request_in.valid        = v;
    request_in.payload.route = route;
    request_in.payload.data  = 24'($urandom);
    for (int i = 0; i < N; i++) fifo_response_signals_in[i].rd_en = rd[i];
    cycle();
  endtask

  task automatic idle(input int n, input logic [3:0] rd);
    for (int k = 0; k < n; k++) drive(1'b0, 8'(k), rd);
  endtask

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    areset        = 1'b1;
    request_in    = '0;
    fifo_response_signals_in = '0;
    model_reset();
    @(negedge ap_clk);
    compare_all();
    check("reset_in_signals", 64'(fifo_request_signals_out), 64'(2'b10));
    check("reset_drop", 64'(drop_count), 64'd0);
    areset = 1'b0;

    // Packets offered during setup must be ignored.
    drive(1'b1, 8'd0, 4'hF);
    drive(1'b1, 8'd1, 4'hF);
    check("setup_released", 64'(fifo_setup_signal), 64'd0);

    // One packet to each destination, all consumers ready.
    for (int i = 0; i < N; i++) drive(1'b1, 8'(i), 4'hF);
    idle(6, 4'hF);
    check("s1_drop", 64'(drop_count), 64'd0);

    // Head-of-line fill on destination 2.
    for (int i = 0; i < 6; i++) drive(1'b1, 8'd2, 4'b1011);
    idle(4, 4'b1011);
    check("s2_in_pf_low", 64'(fifo_request_signals_out.prog_full), 64'd0);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'd2, 4'b1011);
    idle(3, 4'b1011);
    check("s2_in_pf_high", 64'(fifo_request_signals_out.prog_full), 64'd1);
    idle(15, 4'hF);

    // Out-of-range id then a normal one.
    drive(1'b1, 8'd5, 4'hF);
    drive(1'b1, 8'd0, 4'hF);
    idle(8, 4'hF);
    check("s3_drop", 64'(drop_count), 64'd1);

    // Fill destination 0, then overrun the input FIFO.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'd0, 4'h0);
    idle(4, 4'h0);
    for (int i = 0; i < 9; i++) drive(1'b1, 8'd0, 4'h0);
    idle(3, 4'h0);
    check("s4_overflow", 64'(overflow_error), 64'd1);
    idle(25, 4'hF);

    // Broadcast id against a full destination 1.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'd1, 4'b1101);
    idle(5, 4'b1101);
    drive(1'b1, 8'd7, 4'b1101);
    idle(4, 4'b1101);
    idle(10, 4'hF);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      drive(1'($urandom), 8'($urandom), 4'($urandom));
    end
    idle(30, 4'hF);

    // Reset with packets buffered.
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(i), 4'h0);
    idle(2, 4'h0);
    areset = 1'b1;
    model_reset();
    #1;
    compare_all();
    check("midreset_setup", 64'(fifo_setup_signal), 64'd1);
    idle(2, 4'hF);
    areset = 1'b0;
    idle(10, 4'hF);
    check("post_reset_overflow", 64'(overflow_error), 64'd0);
    drive(1'b1, 8'd3, 4'hF);
    idle(6, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
